// File: rtl/mode_pkg.sv
// Privilege mode encoding shared across the core; trap_ctrl reuses it as-is.
package mode;
    typedef enum logic [1:0] {
        U = 2'b00,
        S = 2'b01,
        M = 2'b11
    } mode_t;
endpackage

// File: rtl/trap_pkg.sv
// Shared types and constants for the trap controller and its vector calculator.
package trap_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REDIR = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [1:0] VEC_MODE = 2'b01;
    localparam int         INT_BIT  = 31;
endpackage

// File: rtl/trap_vector.sv
// Trap target from a tvec CSR and an mcause value; vectored mode offsets
// only asynchronous interrupts, exceptions always land on the base.
module trap_vector
    import trap_pkg::*;
(
    input  logic [31:0] i_tvec,
    input  logic [31:0] i_cause,
    output logic [31:0] o_target
);
    logic [31:0] w_base;

    assign w_base = {i_tvec[31:2], 2'b00};

    always_comb begin
        o_target = w_base;
        if (i_tvec[1:0] == VEC_MODE && i_cause[INT_BIT])
            o_target = w_base + {1'b0, i_cause[INT_BIT-1:0]};
    end
endmodule

// File: rtl/trap_ctrl.sv
// Trap entry / xRET sequencer: IDLE -> REDIR (redirect + flush) -> DRAIN (flush) -> IDLE.
// Optional S-mode delegation and sret are enabled with `define TRAP_DELEG_EN.
//
//   state    | meaning
//   ST_IDLE  | accepting xRET or exception, nothing in flight
//   ST_REDIR | CSRs updated, redirect_valid and flush asserted
//   ST_DRAIN | flush held one more cycle, inputs ignored
module trap_ctrl
    import trap_pkg::*;
(
    input  logic         clk,
    input  logic         nrst,
    input  logic         exc_valid,
    input  logic [31:0]  exc_cause,
    input  logic [31:0]  exc_pc,
    input  logic         mret_i,
    input  logic         sret_i,
    input  logic [31:0]  mtvec_i,
    input  logic [31:0]  stvec_i,
`ifdef TRAP_DELEG_EN
    input  logic [31:0]  medeleg_i,
    input  logic [31:0]  mideleg_i,
`endif
    output logic         redirect_valid,
    output logic [31:0]  redirect_pc,
    output logic         flush,
    output logic         busy,
    output mode::mode_t  current_mode,
    output logic [31:0]  mepc,
    output logic [31:0]  mcause,
    output logic [31:0]  sepc,
    output logic [31:0]  scause,
    output logic         mie,
    output logic         mpie,
    output logic         sie,
    output logic         spie,
    output logic         spp,
    output logic [1:0]   mpp
);
    state_t       r_state;
    logic         w_deleg;
    logic [31:0]  w_tvec;
    logic [31:0]  w_target;

`ifdef TRAP_DELEG_EN
    logic [31:0]  w_deleg_vec;

    assign w_deleg_vec = exc_cause[INT_BIT] ? mideleg_i : medeleg_i;
    assign w_deleg     = (current_mode == mode::U || current_mode == mode::S)
                         && w_deleg_vec[exc_cause[4:0]];
`else
    logic         w_unused_sret;

    assign w_unused_sret = sret_i;
    assign w_deleg       = 1'b0;
    assign sepc          = '0;
    assign scause        = '0;
    assign sie           = 1'b0;
    assign spie          = 1'b0;
    assign spp           = 1'b0;
`endif

    assign w_tvec = w_deleg ? stvec_i : mtvec_i;
    assign busy   = (r_state != ST_IDLE);

    trap_vector u_vector (
        .i_tvec   (w_tvec),
        .i_cause  (exc_cause),
        .o_target (w_target)
    );

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state        <= ST_IDLE;
            current_mode   <= mode::M;
            mepc           <= '0;
            mcause         <= '0;
            mie            <= 1'b0;
            mpie           <= 1'b0;
            mpp            <= mode::U;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
`ifdef TRAP_DELEG_EN
            sepc           <= '0;
            scause         <= '0;
            sie            <= 1'b0;
            spie           <= 1'b0;
            spp            <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (mret_i) begin
                        current_mode   <= mode::mode_t'(mpp);
                        mie            <= mpie;
                        mpie           <= 1'b1;
                        mpp            <= mode::U;
                        redirect_pc    <= mepc;
                        redirect_valid <= 1'b1;
                        flush          <= 1'b1;
                        r_state        <= ST_REDIR;
`ifdef TRAP_DELEG_EN
                    end else if (sret_i) begin
                        current_mode   <= mode::mode_t'({1'b0, spp});
                        sie            <= spie;
                        spie           <= 1'b1;
                        spp            <= 1'b0;
                        redirect_pc    <= sepc;
                        redirect_valid <= 1'b1;
                        flush          <= 1'b1;
                        r_state        <= ST_REDIR;
`endif
                    end else if (exc_valid) begin
                        if (w_deleg) begin
`ifdef TRAP_DELEG_EN
                            sepc         <= exc_pc;
                            scause       <= exc_cause;
                            spie         <= sie;
                            sie          <= 1'b0;
                            spp          <= current_mode[0];
                            current_mode <= mode::S;
`endif
                        end else begin
                            mepc         <= exc_pc;
                            mcause       <= exc_cause;
                            mpie         <= mie;
                            mie          <= 1'b0;
                            mpp          <= current_mode;
                            current_mode <= mode::M;
                        end
                        redirect_pc    <= w_target;
                        redirect_valid <= 1'b1;
                        flush          <= 1'b1;
                        r_state        <= ST_REDIR;
                    end
                end
                ST_REDIR: begin
                    redirect_valid <= 1'b0;
                    flush          <= 1'b1;
                    r_state        <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    redirect_valid <= 1'b0;
                    flush          <= 1'b0;
                    r_state        <= ST_IDLE;
                end
                default: begin
                    redirect_valid <= 1'b0;
                    flush          <= 1'b0;
                    r_state        <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl; follows TRAP_DELEG_EN to pick delegated or M-mode expectations.
module tb_trap_ctrl;
    logic         clk = 1'b0;
    logic         nrst;
    logic         exc_valid;
    logic [31:0]  exc_cause;
    logic [31:0]  exc_pc;
    logic         mret_i;
    logic         sret_i;
    logic [31:0]  mtvec_i;
    logic [31:0]  stvec_i;
`ifdef TRAP_DELEG_EN
    logic [31:0]  medeleg_i;
    logic [31:0]  mideleg_i;
`endif
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic         flush;
    logic         busy;
    mode::mode_t  current_mode;
    logic [31:0]  mepc, mcause, sepc, scause;
    logic         mie, mpie, sie, spie, spp;
    logic [1:0]   mpp;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    trap_ctrl dut (
        .clk            (clk),
        .nrst           (nrst),
        .exc_valid      (exc_valid),
        .exc_cause      (exc_cause),
        .exc_pc         (exc_pc),
        .mret_i         (mret_i),
        .sret_i         (sret_i),
        .mtvec_i        (mtvec_i),
        .stvec_i        (stvec_i),
`ifdef TRAP_DELEG_EN
        .medeleg_i      (medeleg_i),
        .mideleg_i      (mideleg_i),
`endif
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .busy           (busy),
        .current_mode   (current_mode),
        .mepc           (mepc),
        .mcause         (mcause),
        .sepc           (sepc),
        .scause         (scause),
        .mie            (mie),
        .mpie           (mpie),
        .sie            (sie),
        .spie           (spie),
        .spp            (spp),
        .mpp            (mpp)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset then mret with mpp=U: ends in U mode, mpie=1, mie=0, idle.
    task automatic go_user();
        nrst = 1'b0; tick(); nrst = 1'b1;
        mret_i = 1'b1; tick(); mret_i = 1'b0;
        tick(); tick();
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        tick(); tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL rst_rv got=%b exp=0", redirect_valid); end
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL rst_flush got=%b exp=0", flush); end
        checks++; if (redirect_pc !== 32'h0) begin failures++; $display("FAIL rst_rpc got=%h exp=0", redirect_pc); end
        checks++; if (current_mode !== mode::M) begin failures++; $display("FAIL rst_mode got=%b exp=11", current_mode); end
        checks++; if (mepc !== 32'h0 || mcause !== 32'h0) begin failures++; $display("FAIL rst_mcsr got=%h/%h exp=0/0", mepc, mcause); end
        checks++; if (mpp !== 2'b00 || mie !== 1'b0 || mpie !== 1'b0) begin failures++; $display("FAIL rst_mstatus got=%b/%b/%b exp=00/0/0", mpp, mie, mpie); end
        checks++; if (sepc !== 32'h0 || scause !== 32'h0 || {sie, spie, spp} !== 3'b000) begin failures++; $display("FAIL rst_scsr got=%h/%h/%b exp=0/0/000", sepc, scause, {sie, spie, spp}); end
        nrst = 1'b1;
    endtask

    task automatic test_mret_to_user();
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
        checks++; if (redirect_valid !== 1'b1 || flush !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL m2u_redir got=%b%b%b exp=111", redirect_valid, flush, busy); end
        checks++; if (redirect_pc !== 32'h0) begin failures++; $display("FAIL m2u_rpc got=%h exp=0", redirect_pc); end
        checks++; if (current_mode !== mode::U || mpie !== 1'b1 || mie !== 1'b0) begin failures++; $display("FAIL m2u_state got=%b/%b/%b exp=00/1/0", current_mode, mpie, mie); end
        tick(); tick();
        checks++; if (busy !== 1'b0 || flush !== 1'b0) begin failures++; $display("FAIL m2u_idle got=%b%b exp=00", busy, flush); end
    endtask

    task automatic test_trap_direct();
        mtvec_i = 32'h100; exc_cause = 32'd2; exc_pc = 32'h40; exc_valid = 1'b1;
        tick();
        checks++; if (redirect_valid !== 1'b1 || flush !== 1'b1) begin failures++; $display("FAIL dir_redir got=%b%b exp=11", redirect_valid, flush); end
        checks++; if (redirect_pc !== 32'h100) begin failures++; $display("FAIL dir_rpc got=%h exp=100", redirect_pc); end
        checks++; if (mepc !== 32'h40 || mcause !== 32'd2) begin failures++; $display("FAIL dir_csr got=%h/%h exp=40/2", mepc, mcause); end
        checks++; if (mpp !== 2'b00 || current_mode !== mode::M) begin failures++; $display("FAIL dir_mode got=%b/%b exp=00/11", mpp, current_mode); end
        checks++; if (mie !== 1'b0 || mpie !== 1'b0) begin failures++; $display("FAIL dir_ie got=%b/%b exp=0/0", mie, mpie); end
        tick();
        checks++; if (redirect_valid !== 1'b0 || flush !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL dir_drain got=%b%b%b exp=011", redirect_valid, flush, busy); end
        exc_valid = 1'b0;
        tick();
        checks++; if (flush !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL dir_idle got=%b%b exp=00", flush, busy); end
    endtask

    task automatic test_mret_return();
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h40) begin failures++; $display("FAIL mret_rpc got=%b/%h exp=1/40", redirect_valid, redirect_pc); end
        checks++; if (current_mode !== mode::U || mie !== 1'b0 || mpie !== 1'b1 || mpp !== 2'b00) begin failures++; $display("FAIL mret_state got=%b/%b/%b/%b exp=00/0/1/00", current_mode, mie, mpie, mpp); end
        tick(); tick();
    endtask

    task automatic test_vectored();
        mtvec_i = 32'h101; exc_cause = 32'h8000_0007; exc_pc = 32'h84; exc_valid = 1'b1;
        tick();
        exc_valid = 1'b0;
        checks++; if (redirect_pc !== 32'h107) begin failures++; $display("FAIL vec_int_rpc got=%h exp=107", redirect_pc); end
        checks++; if (mcause !== 32'h8000_0007 || mepc !== 32'h84) begin failures++; $display("FAIL vec_int_csr got=%h/%h exp=80000007/84", mcause, mepc); end
        checks++; if (current_mode !== mode::M || mpp !== 2'b00) begin failures++; $display("FAIL vec_int_mode got=%b/%b exp=11/00", current_mode, mpp); end
        tick(); tick();
        exc_cause = 32'd5; exc_pc = 32'h88; exc_valid = 1'b1;
        tick();
        exc_valid = 1'b0;
        checks++; if (redirect_pc !== 32'h100) begin failures++; $display("FAIL vec_exc_rpc got=%h exp=100", redirect_pc); end
        checks++; if (mcause !== 32'd5 || mpp !== 2'b11) begin failures++; $display("FAIL vec_exc_csr got=%h/%b exp=5/11", mcause, mpp); end
        tick(); tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL vec_idle got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        mret_i = 1'b1; exc_valid = 1'b1; exc_cause = 32'h0B; exc_pc = 32'h90;
        tick();
        mret_i = 1'b0;
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h88) begin failures++; $display("FAIL b2b_ret_rpc got=%b/%h exp=1/88", redirect_valid, redirect_pc); end
        checks++; if (mcause !== 32'd5 || mepc !== 32'h88) begin failures++; $display("FAIL b2b_ret_csr got=%h/%h exp=5/88", mcause, mepc); end
        checks++; if (current_mode !== mode::M || mpp !== 2'b00 || mpie !== 1'b1 || mie !== 1'b0) begin failures++; $display("FAIL b2b_ret_state got=%b/%b/%b/%b exp=11/00/1/0", current_mode, mpp, mpie, mie); end
        tick();
        checks++; if (mcause !== 32'd5 || flush !== 1'b1 || redirect_valid !== 1'b0) begin failures++; $display("FAIL b2b_hold got=%h/%b%b exp=5/10", mcause, flush, redirect_valid); end
        tick();
        checks++; if (busy !== 1'b0 || mcause !== 32'd5) begin failures++; $display("FAIL b2b_idle got=%b/%h exp=0/5", busy, mcause); end
        tick();
        exc_valid = 1'b0;
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h100) begin failures++; $display("FAIL b2b_trap_rpc got=%b/%h exp=1/100", redirect_valid, redirect_pc); end
        checks++; if (mcause !== 32'h0B || mepc !== 32'h90 || mpp !== 2'b11 || mpie !== 1'b0) begin failures++; $display("FAIL b2b_trap_csr got=%h/%h/%b/%b exp=b/90/11/0", mcause, mepc, mpp, mpie); end
        tick(); tick();
    endtask

`ifndef TRAP_DELEG_EN
    task automatic test_sret_ignored();
        sret_i = 1'b1;
        tick();
        sret_i = 1'b0;
        checks++; if (busy !== 1'b0 || redirect_valid !== 1'b0 || current_mode !== mode::M) begin failures++; $display("FAIL sret_ign got=%b%b/%b exp=00/11", busy, redirect_valid, current_mode); end
    endtask
`endif

    task automatic test_deleg();
        go_user();
        checks++; if (current_mode !== mode::U) begin failures++; $display("FAIL dlg_pre_mode got=%b exp=00", current_mode); end
`ifdef TRAP_DELEG_EN
        medeleg_i = 32'h100; mideleg_i = 32'h0;
`endif
        stvec_i = 32'h200; mtvec_i = 32'h300; exc_cause = 32'd8; exc_pc = 32'h60; exc_valid = 1'b1;
        tick();
        exc_valid = 1'b0;
`ifdef TRAP_DELEG_EN
        checks++; if (current_mode !== mode::S || redirect_pc !== 32'h200) begin failures++; $display("FAIL dlg_mode got=%b/%h exp=01/200", current_mode, redirect_pc); end
        checks++; if (sepc !== 32'h60 || scause !== 32'd8 || {sie, spie, spp} !== 3'b000) begin failures++; $display("FAIL dlg_scsr got=%h/%h/%b exp=60/8/000", sepc, scause, {sie, spie, spp}); end
        checks++; if (mepc !== 32'h0 || mcause !== 32'h0) begin failures++; $display("FAIL dlg_mcsr got=%h/%h exp=0/0", mepc, mcause); end
        tick(); tick();
        sret_i = 1'b1;
        tick();
        sret_i = 1'b0;
        checks++; if (current_mode !== mode::U || redirect_pc !== 32'h60 || redirect_valid !== 1'b1) begin failures++; $display("FAIL sret_ret got=%b/%h/%b exp=00/60/1", current_mode, redirect_pc, redirect_valid); end
        checks++; if (spie !== 1'b1 || sie !== 1'b0 || spp !== 1'b0) begin failures++; $display("FAIL sret_bits got=%b/%b/%b exp=1/0/0", spie, sie, spp); end
`else
        checks++; if (current_mode !== mode::M || redirect_pc !== 32'h300) begin failures++; $display("FAIL nodlg_mode got=%b/%h exp=11/300", current_mode, redirect_pc); end
        checks++; if (mepc !== 32'h60 || mcause !== 32'd8 || sepc !== 32'h0) begin failures++; $display("FAIL nodlg_csr got=%h/%h/%h exp=60/8/0", mepc, mcause, sepc); end
`endif
        tick(); tick();
    endtask

    task automatic test_reset_abort();
        mtvec_i = 32'h100; exc_cause = 32'd3; exc_pc = 32'h44; exc_valid = 1'b1;
        tick();
        checks++; if (redirect_valid !== 1'b1 || mepc !== 32'h44) begin failures++; $display("FAIL abort_pre got=%b/%h exp=1/44", redirect_valid, mepc); end
        nrst = 1'b0; exc_valid = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || flush !== 1'b0 || redirect_valid !== 1'b0) begin failures++; $display("FAIL abort_fsm got=%b%b%b exp=000", busy, flush, redirect_valid); end
        checks++; if (current_mode !== mode::M || mepc !== 32'h0 || mcause !== 32'h0 || redirect_pc !== 32'h0) begin failures++; $display("FAIL abort_csr got=%b/%h/%h/%h exp=11/0/0/0", current_mode, mepc, mcause, redirect_pc); end
        nrst = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_after got=%b exp=0", busy); end
    endtask

    initial begin
        nrst = 1'b0; exc_valid = 1'b0; exc_cause = '0; exc_pc = '0;
        mret_i = 1'b0; sret_i = 1'b0; mtvec_i = '0; stvec_i = '0;
`ifdef TRAP_DELEG_EN
        medeleg_i = '0; mideleg_i = '0;
`endif
        test_reset();
        test_mret_to_user();
        test_trap_direct();
        test_mret_return();
        test_vectored();
        test_back_to_back();
`ifndef TRAP_DELEG_EN
        test_sret_ignored();
`endif
        test_deleg();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 clk  in  1  system clock; all state changes on posedge clk.
REQ-002 nrst  in  1  reset, synchronous and active-low.
REQ-003 exc_valid  in  1  exception/interrupt pending from execute stage, level-held until flushed.
REQ-004 exc_cause  in  32  mcause encoding: bit31 = interrupt, bits30:0 = code.
REQ-005 exc_pc  in  32  word-addressed PC of the faulting instruction.
REQ-006 mret_i, sret_i  in  1 each  xRET commit strobes.
REQ-007 mtvec_i, stvec_i  in  32 each  trap vector CSRs; bits1:0 = mode (0 direct, 1 vectored).
REQ-008 medeleg_i, mideleg_i  in  32 each  delegation CSRs; present only with TRAP_DELEG_EN.
REQ-009 redirect_valid  out  1  one-cycle PC redirect strobe.
REQ-010 redirect_pc  out  32  redirect target.
REQ-011 flush  out  1  pipeline kill.
REQ-012 busy  out  1  high when the FSM is not IDLE.
REQ-013 current_mode  out  mode::mode_t  privilege mode.
REQ-014 mepc, mcause, sepc, scause  out  32 each  trap CSR state.
REQ-015 mie, mpie, sie, spie, spp  out  1 each; mpp  out  2  mstatus fields.

Function
REQ-016 FSM states SHALL be IDLE, REDIR, DRAIN; busy = (state != IDLE).
REQ-017 In IDLE, mret_i or sret_i set -> return path; otherwise exc_valid set -> trap path. xRET SHALL win when it coincides with exc_valid.
REQ-018 Trap path: at edge N+1 the CSRs update, state -> REDIR; redirect_valid=1 and flush=1 during N+1.
REQ-019 Trap path, cont.: DRAIN during N+2 with flush=1 and redirect_valid=0; IDLE at N+3.
REQ-020 Inputs SHALL be ignored in REDIR and DRAIN.
REQ-021 M-trap update: mepc<=exc_pc, mcause<=exc_cause, mpie<=mie, mie<=0, mpp<=current_mode, current_mode<=M.
REQ-022 Target SHALL be {tvec[31:2],2'b00} when direct, or when vectored with bit31=0.
REQ-023 Target SHALL be {tvec[31:2],2'b00} + cause[30:0] when vectored and bit31=1; add is 32-bit, wrap-around ignored.
REQ-024 mret: current_mode<=mpp, mie<=mpie, mpie<=1, mpp<=U, redirect_pc=mepc; same REDIR/DRAIN timing.
REQ-025 Return and trap SHALL never update CSRs in the same cycle.

Reset
REQ-026 nrst=0 at an edge SHALL force: state IDLE, current_mode=M, all CSR outputs 0, mpp=U, redirect_valid=0, flush=0, redirect_pc=0.
REQ-027 Reset asserted during REDIR or DRAIN SHALL abort the sequence; no partial CSR update survives.

Configuration
REQ-028 With TRAP_DELEG_EN defined: a trap is delegated when current_mode<=S and the deleg bit selected by cause[4:0] is set (mideleg_i for interrupts, medeleg_i otherwise).
REQ-029 A delegated trap SHALL update sepc, scause, spie<=sie, sie<=0, spp<=current_mode[0], current_mode<=S, and target stvec_i.
REQ-030 With TRAP_DELEG_EN defined, sret SHALL set current_mode<={1'b0,spp}, sie<=spie, spie<=1, spp<=0, redirect_pc=sepc.
REQ-031 Without TRAP_DELEG_EN: medeleg_i/mideleg_i ports are absent, sret_i is ignored, all traps go to M, and the sepc/scause/sie/spie/spp outputs are tied to 0.

Structure
REQ-032 Package trap_pkg SHALL hold the FSM state enum, the VEC_MODE constant and the INT_BIT=31 index; mode::mode_t is reused unchanged.
REQ-033 Sub-module trap_vector (combinational target calculation from tvec and cause) SHALL be instantiated once.

Verification
REQ-034 mtvec=0x100 direct, cause=2, exc_pc=0x40, mode U -> redirect_pc=0x100, mepc=0x40, mpp=U, mode=M, flush for 2 cycles.
REQ-035 mtvec=0x101, cause=0x80000007 -> redirect_pc=0x107, mcause=0x80000007.
REQ-036 After REQ-034, mret_i=1 -> mode=U, mie=old mpie, mpie=1, redirect_pc=0x40.
REQ-037 mret_i and exc_valid in the same cycle -> return taken, mcause unchanged; exc_valid held during REDIR has no effect.
REQ-038 TRAP_DELEG_EN, mode U, medeleg=0x100, cause=8 -> mode=S, sepc=exc_pc, target=stvec; repeat without the macro -> mode=M.
REQ-039 nrst=0 during REDIR -> next cycle IDLE, flush=0, mode=M, mepc=0.
